parking_gate_ctrl: RTL and testbench



---
 rtl/parking_pkg.sv | 29 ++
 rtl/parking_digit_collector.sv | 48 ++++
 rtl/parking_gate_ctrl.sv | 166 ++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate session controller.
// Passwords are three BCD digits, first digit in the top nibble.
package parking_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int CODE_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [CODE_W-1:0] PW_IN  = 12'h123;
  localparam logic [CODE_W-1:0] PW_OUT = 12'h234;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    OPEN,
    LOCKED
  } state_t;

  typedef enum logic {
    SIDE_IN,
    SIDE_OUT
  } side_t;

  function automatic logic [CODE_W-1:0] side_password(input side_t side);
    return (side == SIDE_OUT) ? PW_OUT : PW_IN;
  endfunction

endpackage

// File: rtl/parking_digit_collector.sv
// Three-digit code shift register with digit count and inter-digit timeout.
// Strobes are combinational so the owning FSM can move on the accepting edge.
module parking_digit_collector
  import parking_pkg::*;
#(
  parameter int DIGIT_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_first,
  input  logic               shift,
  input  logic               active,
  input  logic [DIGIT_W-1:0] digit,
  output logic [CODE_W-1:0]  code,
  output logic               complete,
  output logic               timeout
);

  localparam int TW = $clog2(DIGIT_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(DIGIT_TIMEOUT - 1);

  logic [1:0]    count;
  logic [TW-1:0] idle_cnt;

  assign complete = shift && (count == 2'(NUM_DIGITS - 1));
  assign timeout  = active && !shift && (idle_cnt == T_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      code     <= '0;
      count    <= '0;
      idle_cnt <= '0;
    end else if (load_first) begin
      code     <= CODE_W'(digit);
      count    <= 2'd1;
      idle_cnt <= '0;
    end else if (shift) begin
      code     <= {code[CODE_W-DIGIT_W-1:0], digit};
      count    <= count + 2'd1;
      idle_cnt <= '0;
    end else if (active) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Smart-parking session controller: keypad arbitration, code check, gate timing,
// occupancy tracking and lockout after repeated wrong codes.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY      = 8,
  parameter int GATE_CYCLES   = 50,
  parameter int DIGIT_TIMEOUT = 200,
  parameter int MAX_FAILS     = 3,
  parameter int LOCK_CYCLES   = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_key_valid,
  input  logic [3:0]                    in_key_digit,
  input  logic                          out_key_valid,
  input  logic [3:0]                    out_key_digit,
  output logic                          gate_in_open,
  output logic                          gate_out_open,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic                          full,
  output logic                          lockout,
  output logic                          busy,
  output logic                          code_err
);

  localparam int OW = $clog2(CAPACITY + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [OW-1:0] OCC_MAX = OW'(CAPACITY);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);

  state_t        state, state_n;
  side_t         side, side_n;
  logic [FW-1:0] fails, fails_n;
  logic [TW-1:0] timer, timer_n;
  logic [OW-1:0] occ_n;
  logic          err_n;

  logic               load_first, shift;
  logic [DIGIT_W-1:0] collect_digit;
  logic [CODE_W-1:0]  code;
  logic               complete, timeout;

  logic               owner_valid;
  logic [DIGIT_W-1:0] owner_digit;

  assign owner_valid = (side == SIDE_OUT) ? out_key_valid : in_key_valid;
  assign owner_digit = (side == SIDE_OUT) ? out_key_digit : in_key_digit;

  parking_digit_collector #(
    .DIGIT_TIMEOUT(DIGIT_TIMEOUT)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .load_first(load_first),
    .shift     (shift),
    .active    (state == COLLECT),
    .digit     (collect_digit),
    .code      (code),
    .complete  (complete),
    .timeout   (timeout)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    side_n        = side;
    fails_n       = fails;
    timer_n       = timer;
    occ_n         = occupancy;
    err_n         = 1'b0;
    load_first    = 1'b0;
    shift         = 1'b0;
    collect_digit = owner_digit;

    unique case (state)
      IDLE: begin
        // Exit has priority; a full lot refuses new entry sessions.
        if (out_key_valid) begin
          side_n        = SIDE_OUT;
          load_first    = 1'b1;
          collect_digit = out_key_digit;
          state_n       = COLLECT;
        end else if (in_key_valid && !full) begin
          side_n        = SIDE_IN;
          load_first    = 1'b1;
          collect_digit = in_key_digit;
          state_n       = COLLECT;
        end
      end
      COLLECT: begin
        shift = owner_valid;
        if (complete) begin
          state_n = CHECK;
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      CHECK: begin
        timer_n = '0;
        if (code == side_password(side)) begin
          fails_n = '0;
          state_n = OPEN;
          if (side == SIDE_IN) begin
            if (occupancy != OCC_MAX) occ_n = occupancy + OW'(1);
          end else begin
            if (occupancy != '0) occ_n = occupancy - OW'(1);
          end
        end else begin
          err_n   = 1'b1;
          fails_n = fails + FW'(1);
          state_n = (fails_n == FAIL_MAX) ? LOCKED : IDLE;
        end
      end
      OPEN: begin
        if (timer == GATE_LAST) state_n = IDLE;
        else timer_n = timer + TW'(1);
      end
      LOCKED: begin
        if (timer == LOCK_LAST) begin
          fails_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they are plain flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      side          <= SIDE_IN;
      fails         <= '0;
      timer         <= '0;
      occupancy     <= '0;
      full          <= 1'b0;
      gate_in_open  <= 1'b0;
      gate_out_open <= 1'b0;
      lockout       <= 1'b0;
      busy          <= 1'b0;
      code_err      <= 1'b0;
    end else begin
      state         <= state_n;
      side          <= side_n;
      fails         <= fails_n;
      timer         <= timer_n;
      occupancy     <= occ_n;
      full          <= (occ_n == OCC_MAX);
      gate_in_open  <= (state_n == OPEN) && (side_n == SIDE_IN);
      gate_out_open <= (state_n == OPEN) && (side_n == SIDE_OUT);
      lockout       <= (state_n == LOCKED);
      busy          <= (state_n != IDLE);
      code_err      <= err_n;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed session table, hand-written
// timeout/full/reset sequences, and random sessions scored by a session-level model.
module tb_parking_gate_ctrl;

  localparam int CAP = 8;
  localparam int G   = 50;
  localparam int T   = 200;
  localparam int L   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_key_valid = 1'b0;
  logic [3:0] in_key_digit = '0;
  logic       out_key_valid = 1'b0;
  logic [3:0] out_key_digit = '0;
  logic       gate_in_open, gate_out_open, full, lockout, busy, code_err;
  logic [3:0] occupancy;

  parking_gate_ctrl #(
    .CAPACITY(CAP), .GATE_CYCLES(G), .DIGIT_TIMEOUT(T), .MAX_FAILS(3), .LOCK_CYCLES(L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_key_valid (in_key_valid),
    .in_key_digit (in_key_digit),
    .out_key_valid(out_key_valid),
    .out_key_digit(out_key_digit),
    .gate_in_open (gate_in_open),
    .gate_out_open(gate_out_open),
    .occupancy    (occupancy),
    .full         (full),
    .lockout      (lockout),
    .busy         (busy),
    .code_err     (code_err)
  );

  always #5 clk = ~clk;

  typedef enum {R_OPEN, R_ERR, R_LOCK} result_t;
  typedef struct {
    bit         side_out;
    logic [3:0] d1, d2, d3;
    bit         noise;
    result_t    exp;
    int         exp_occ;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int m_occ = 0;
  int m_fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input bit s, input int a, input int b, input int c,
                             input bit n, input result_t r, input int occ);
    vec_t x;
    x.side_out = s; x.d1 = 4'(a); x.d2 = 4'(b); x.d3 = 4'(c);
    x.noise = n; x.exp = r; x.exp_occ = occ;
    return x;
  endfunction

  // One keypad cycle; the noise digit goes to the other keypad.
  task automatic drive(input bit side_out, input logic [3:0] d, input bit noise, input logic [3:0] nd);
    if (side_out) begin
      out_key_valid = 1'b1; out_key_digit = d;
      in_key_valid = noise; in_key_digit = nd;
    end else begin
      in_key_valid = 1'b1; in_key_digit = d;
      out_key_valid = noise; out_key_digit = nd;
    end
    tick();
    in_key_valid = 1'b0;
    out_key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_key_valid = 1'b0;
    out_key_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    m_occ = 0;
    m_fails = 0;
  endtask

  // Session-level reference: outcome from code vs password, arithmetic occupancy.
  task automatic predict(input bit side_out, input logic [3:0] d1, d2, d3,
                         output result_t r, output int occ);
    logic [11:0] pw;
    pw = side_out ? 12'h234 : 12'h123;
    if ({d1, d2, d3} == pw) begin
      m_fails = 0;
      if (side_out) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
      else m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
      r = R_OPEN;
    end else begin
      m_fails++;
      if (m_fails >= 3) begin
        m_fails = 0;
        r = R_LOCK;
      end else begin
        r = R_ERR;
      end
    end
    occ = m_occ;
  endtask

  // Plays one session from IDLE and checks the t+1 / t+2 / end-of-phase timing.
  task automatic do_session(input bit side_out, input logic [3:0] d1, d2, d3,
                            input bit noise, input result_t exp, input int exp_occ);
    logic [11:0] npw;
    logic        seen;
    npw = side_out ? 12'h123 : 12'h234;
    drive(side_out, d1, noise && side_out, npw[11:8]);
    drive(side_out, d2, noise, npw[7:4]);
    drive(side_out, d3, noise, npw[3:0]);
    check("check_cycle_busy", busy, 1'b1);
    check("check_cycle_gates", {gate_in_open, gate_out_open}, 2'b00);
    tick();
    case (exp)
      R_OPEN: begin
        check("open_gate_in", gate_in_open, !side_out);
        check("open_gate_out", gate_out_open, side_out);
        check("open_occupancy", occupancy, exp_occ);
        check("open_full", full, exp_occ == CAP);
        seen = code_err;
        repeat (G - 1) begin
          tick();
          seen |= code_err;
        end
        check("open_last_cycle", gate_in_open | gate_out_open, 1'b1);
        check("open_no_err", seen, 1'b0);
        tick();
        check("open_closed", {gate_in_open, gate_out_open, busy}, 3'b000);
      end
      R_ERR: begin
        check("err_pulse", code_err, 1'b1);
        check("err_state", {gate_in_open, gate_out_open, busy, lockout}, 4'b0000);
        check("err_occupancy", occupancy, exp_occ);
        tick();
        check("err_pulse_end", code_err, 1'b0);
      end
      R_LOCK: begin
        check("lock_err_pulse", code_err, 1'b1);
        check("lock_rise", {lockout, busy}, 2'b11);
        seen = 1'b0;
        for (int i = 0; i < L - 1; i++) begin
          if (i < 3) begin
            in_key_valid = 1'b1;
            in_key_digit = 4'(i + 1);
          end
          tick();
          in_key_valid = 1'b0;
          seen |= gate_in_open | gate_out_open | code_err;
        end
        check("lock_held", lockout, 1'b1);
        check("lock_digits_ignored", seen, 1'b0);
        tick();
        check("lock_released", {lockout, busy}, 2'b00);
        check("lock_occupancy", occupancy, exp_occ);
      end
      default: ;
    endcase
  endtask

  initial begin
    vec_t    tbl[$];
    result_t r;
    int      occ;
    logic [11:0] pw;
    logic [3:0]  d1, d2, d3;
    bit          s, n;

    repeat (2) tick();
    check("reset_gates", {gate_in_open, gate_out_open}, 2'b00);
    check("reset_occupancy", occupancy, 0);
    check("reset_flags", {full, lockout, busy, code_err}, 4'b0000);
    rst = 1'b1;

    tbl.push_back(v(0, 1, 2, 3, 0, R_OPEN, 1));
    tbl.push_back(v(0, 1, 2, 3, 0, R_OPEN, 2));
    tbl.push_back(v(1, 2, 3, 4, 1, R_OPEN, 1));
    tbl.push_back(v(1, 2, 3, 4, 0, R_OPEN, 0));
    tbl.push_back(v(1, 2, 3, 4, 0, R_OPEN, 0));
    tbl.push_back(v(0, 1, 2, 4, 0, R_ERR, 0));
    tbl.push_back(v(0, 1, 2, 4, 0, R_ERR, 0));
    tbl.push_back(v(0, 1, 2, 4, 0, R_LOCK, 0));
    tbl.push_back(v(0, 1, 2, 3, 0, R_OPEN, 1));
    tbl.push_back(v(0, 1, 2, 11, 0, R_ERR, 1));
    tbl.push_back(v(1, 2, 3, 4, 0, R_OPEN, 0));
    tbl.push_back(v(0, 15, 15, 15, 0, R_ERR, 0));
    tbl.push_back(v(1, 1, 2, 3, 0, R_ERR, 0));
    tbl.push_back(v(0, 1, 2, 3, 0, R_OPEN, 1));
    tbl.push_back(v(0, 2, 3, 4, 0, R_ERR, 1));
    tbl.push_back(v(0, 1, 2, 4, 0, R_ERR, 1));
    tbl.push_back(v(0, 1, 2, 3, 1, R_OPEN, 2));
    foreach (tbl[i])
      do_session(tbl[i].side_out, tbl[i].d1, tbl[i].d2, tbl[i].d3,
                 tbl[i].noise, tbl[i].exp, tbl[i].exp_occ);

    // Timeout aborts without touching the fail count.
    do_reset();
    do_session(0, 4'd1, 4'd2, 4'd4, 0, R_ERR, 0);
    drive(0, 4'd1, 0, 4'd0);
    repeat (T - 1) tick();
    check("timeout_last_count", {busy, code_err}, 2'b10);
    tick();
    check("timeout_pulse", {busy, code_err}, 2'b01);
    tick();
    check("timeout_pulse_end", code_err, 1'b0);
    do_session(0, 4'd1, 4'd2, 4'd4, 0, R_ERR, 0);
    do_session(0, 4'd1, 4'd2, 4'd4, 0, R_LOCK, 0);

    // Full lot ignores the entry keypad.
    do_reset();
    for (int i = 1; i <= CAP; i++) do_session(0, 4'd1, 4'd2, 4'd3, 0, R_OPEN, i);
    check("full_set", full, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 4'(k), 0, 4'd0);
      check("full_entry_ignored", busy, 1'b0);
    end
    do_session(1, 4'd2, 4'd3, 4'd4, 0, R_OPEN, CAP - 1);

    // Reset in the middle of an open gate.
    drive(0, 4'd1, 0, 4'd0);
    drive(0, 4'd2, 0, 4'd0);
    drive(0, 4'd3, 0, 4'd0);
    tick();
    check("pre_reset_open", {gate_in_open, occupancy}, {1'b1, 4'(CAP)});
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("mid_open_reset", {gate_in_open, busy, full, occupancy}, 7'b0);
    rst = 1'b1;
    tick();
    check("after_reset_idle", {gate_in_open, gate_out_open, busy}, 3'b000);

    // Random sessions against the session-level model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      s = 1'($urandom_range(0, 1));
      if (m_occ == CAP) s = 1'b1;
      n = 1'($urandom_range(0, 1));
      pw = s ? 12'h234 : 12'h123;
      if ($urandom_range(0, 2) != 0) begin
        d1 = pw[11:8]; d2 = pw[7:4]; d3 = pw[3:0];
        if ($urandom_range(0, 3) == 0) d3 = 4'($urandom_range(0, 15));
      end else begin
        d1 = 4'($urandom_range(0, 15));
        d2 = 4'($urandom_range(0, 15));
        d3 = 4'($urandom_range(0, 15));
      end
      predict(s, d1, d2, d3, r, occ);
      do_session(s, d1, d2, d3, n, r, occ);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
